// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: RGB222 colour,
// background mode encodings and sprite reset placement.
package sprite_pkg;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  localparam logic [3:0] BG_SOLID     = 4'd0;
  localparam logic [3:0] BG_HBARS     = 4'd1;
  localparam logic [3:0] BG_VBARS     = 4'd2;
  localparam logic [3:0] BG_SCROLL_XP = 4'd3;
  localparam logic [3:0] BG_SCROLL_XM = 4'd4;
  localparam logic [3:0] BG_SCROLL_YP = 4'd5;
  localparam logic [3:0] BG_SCROLL_YM = 4'd6;
  localparam logic [3:0] BG_DIAG_PP   = 4'd7;
  localparam logic [3:0] BG_DIAG_MP   = 4'd8;
  localparam logic [3:0] BG_DIAG_PM   = 4'd9;
  localparam logic [3:0] BG_DIAG_MM   = 4'd10;

  localparam int RST_X0 = 100;
  localparam int RST_Y0 = 80;

  // Sprites start on a diagonal staircase so none overlap out of reset.
  function automatic logic [9:0] rst_x(input int i, input int s);
    return 10'(RST_X0 + i * s);
  endfunction

  function automatic logic [9:0] rst_y(input int i, input int s);
    return 10'(RST_Y0 + i * (s / 2));
  endfunction

endpackage

// File: rtl/sprite_mover.sv
// One bouncing sprite: position and direction per axis, stepping once on
// every enabled cycle and reversing when it reaches a screen edge.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int SPRITE_LOG2 = 5,
  parameter int SPEED       = 1,
  parameter int IDX         = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] x,
  output logic [9:0] y
);
  localparam int         S     = 1 << SPRITE_LOG2;
  localparam logic [9:0] X_MAX = 10'(H_DISPLAY - S);
  localparam logic [9:0] Y_MAX = 10'(V_DISPLAY - S);
  localparam logic [9:0] STEP  = 10'(SPEED);

  logic dx, dy;

  // Returns {dir, pos}; lands exactly on the edge and reverses instead of overshooting.
  function automatic logic [10:0] step(input logic [9:0] p, input logic d, input logic [9:0] lim);
    if (d)
      return ({1'b0, p} + {1'b0, STEP} >= {1'b0, lim}) ? {1'b0, lim} : {1'b1, p + STEP};
    return (p <= STEP) ? {1'b1, 10'd0} : {1'b0, p - STEP};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      x  <= rst_x(IDX, S);
      y  <= rst_y(IDX, S);
      dx <= 1'b1;
      dy <= 1'(IDX % 2);
    end else if (en) begin
      {dx, x} <= step(x, dx, X_MAX);
      {dy, y} <= step(y, dy, Y_MAX);
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// N bouncing sprites over a scrollable background, two-cycle registered RGB.
// Define SPRITE_TRANSPARENCY_EN to let TRANSPARENT_KEY texels show background.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int         H_DISPLAY       = 640,
  parameter int         V_DISPLAY       = 480,
  parameter int         N_SPRITES       = 4,
  parameter int         SPRITE_LOG2     = 5,
  parameter int         SPEED           = 1,
  parameter logic [5:0] SOLID_COLOR     = 6'h3F,
  parameter logic [5:0] TRANSPARENT_KEY = 6'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [9:0]               hpos,
  input  logic [9:0]               vpos,
  input  logic                     visible,
  input  logic [7:0]               vga_control,
  output logic [2*SPRITE_LOG2-1:0] rom_addr,
  input  logic [5:0]               rom_data,
  output logic [1:0]               R,
  output logic [1:0]               G,
  output logic [1:0]               B
);
  logic [9:0] prev_vpos, scroll;
  logic [3:0] mode_q;
  logic       freeze_q, tick;

  // Frame boundary seen from the pixel clock domain: vpos wrapping back to 0.
  assign tick = (vpos == 10'd0) && (prev_vpos != 10'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vpos <= '0;
      scroll    <= '0;
      mode_q    <= BG_SOLID;
      freeze_q  <= 1'b0;
    end else begin
      prev_vpos <= vpos;
      if (tick) begin
        mode_q   <= vga_control[3:0];
        freeze_q <= vga_control[4];
        if (!freeze_q) scroll <= scroll + 10'd1;
      end
    end
  end

  logic [N_SPRITES-1:0][9:0] spr_x, spr_y, off_x, off_y;
  logic [N_SPRITES-1:0]      hit;

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_spr
    sprite_mover #(
      .H_DISPLAY  (H_DISPLAY),
      .V_DISPLAY  (V_DISPLAY),
      .SPRITE_LOG2(SPRITE_LOG2),
      .SPEED      (SPEED),
      .IDX        (i)
    ) u_mover (
      .clk(clk),
      .rst(rst),
      .en (tick && !freeze_q),
      .x  (spr_x[i]),
      .y  (spr_y[i])
    );
    assign off_x[i] = hpos - spr_x[i];
    assign off_y[i] = vpos - spr_y[i];
    assign hit[i]   = (off_x[i][9:SPRITE_LOG2] == '0) && (off_y[i][9:SPRITE_LOG2] == '0);
  end

  // Scan from the top index down so the lowest-index hit is the last write.
  logic any_hit;
  always_comb begin
    any_hit  = 1'b0;
    rom_addr = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit  = 1'b1;
        rom_addr = {off_y[i][SPRITE_LOG2-1:0], off_x[i][SPRITE_LOG2-1:0]};
      end
    end
  end

  logic       x_neg, y_neg;
  logic [9:0] mx, my;
  rgb222_t    bg;

  always_comb begin
    x_neg = 1'b0;
    y_neg = 1'b0;
    case (mode_q)
      BG_SCROLL_XM, BG_DIAG_MP: x_neg = 1'b1;
      BG_SCROLL_YM, BG_DIAG_PM: y_neg = 1'b1;
      BG_DIAG_MM: begin
        x_neg = 1'b1;
        y_neg = 1'b1;
      end
      default: ;
    endcase
    mx = x_neg ? hpos - scroll : hpos + scroll;
    my = y_neg ? vpos - scroll : vpos + scroll;
  end

  always_comb begin
    bg = '0;
    case (mode_q)
      BG_SOLID:                   bg = SOLID_COLOR;
      BG_HBARS:                   bg = {hpos[5], vpos[1], hpos[6], vpos[1], hpos[7], vpos[1]};
      BG_VBARS:                   bg = {vpos[5], hpos[1], vpos[6], hpos[1], vpos[7], hpos[1]};
      BG_SCROLL_XP, BG_SCROLL_XM: bg = {mx[5], vpos[2], mx[6], vpos[2], mx[7], vpos[2]};
      BG_SCROLL_YP, BG_SCROLL_YM: bg = {my[5], vpos[2], my[6], vpos[2], my[7], vpos[2]};
      BG_DIAG_PP, BG_DIAG_MP,
      BG_DIAG_PM, BG_DIAG_MM:     bg = {my[5], mx[2], my[6], mx[2], my[7], mx[2]};
      default:                    bg = '0;
    endcase
  end

  logic    s1_hit, s1_vis;
  rgb222_t s1_bg, px;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit <= 1'b0;
      s1_vis <= 1'b0;
      s1_bg  <= '0;
    end else begin
      s1_hit <= any_hit;
      s1_vis <= visible;
      s1_bg  <= bg;
    end
  end

  // Single ROM port: a keyed texel exposes background, never a lower sprite.
  logic see_through;
`ifdef SPRITE_TRANSPARENCY_EN
  assign see_through = (rom_data == TRANSPARENT_KEY);
`else
  assign see_through = 1'b0;
`endif

  always_comb begin
    px = s1_bg;
    if (!s1_vis)                      px = '0;
    else if (s1_hit && !see_through)  px = rom_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= px.r;
      G <= px.g;
      B <= px.b;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{mx[9:8], mx[4:3], mx[1:0], my[9:8], my[4:0],
                         vga_control[7:5], TRANSPARENT_KEY};

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a small motion/background model
// and a registered ROM stand-in; honours SPRITE_TRANSPARENCY_EN.
module tb_sprite_compositor;
  import sprite_pkg::*;

  localparam int N = 4, S = 32, HMAX = 608, VMAX = 448;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos, vpos;
  logic       visible;
  logic [7:0] vga_control;
  logic [9:0] rom_addr;
  logic [5:0] rom_data;
  logic [1:0] R, G, B;

  always #5 clk = ~clk;

  sprite_compositor #(.N_SPRITES(N)) dut (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .visible(visible),
    .vga_control(vga_control), .rom_addr(rom_addr), .rom_data(rom_data),
    .R(R), .G(G), .B(B)
  );

  function automatic logic [5:0] rom_f(input logic [9:0] a);
    return a[5:0] ^ 6'h15;
  endfunction

  always_ff @(posedge clk) rom_data <= rom_f(rom_addr);

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- model ----
  int         sx[N], sy[N];
  bit         sdx[N], sdy[N];
  logic [9:0] m_scroll, last_v;
  logic [3:0] m_mode;
  bit         m_freeze;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      sx[i] = 100 + i * S; sy[i] = 80 + i * (S / 2);
      sdx[i] = 1'b1; sdy[i] = (i % 2) == 1;
    end
    m_scroll = 0; m_mode = 0; m_freeze = 0;
  endtask

  task automatic m_axis(inout int p, inout bit d, input int lim);
    if (d) begin
      p = p + 1;
      if (p >= lim) begin p = lim; d = 1'b0; end
    end else begin
      p = p - 1;
      if (p <= 0) begin p = 0; d = 1'b1; end
    end
  endtask

  task automatic m_tick();
    if (!m_freeze) begin
      m_scroll = m_scroll + 1;
      for (int i = 0; i < N; i++) begin
        m_axis(sx[i], sdx[i], HMAX);
        m_axis(sy[i], sdy[i], VMAX);
      end
    end
    m_mode = vga_control[3:0];
    m_freeze = vga_control[4];
  endtask

  function automatic logic [5:0] bg_f(input logic [9:0] h, input logic [9:0] v);
    logic [9:0] xp, xm, yp, ym;
    xp = h + m_scroll; xm = h - m_scroll; yp = v + m_scroll; ym = v - m_scroll;
    case (m_mode)
      4'd0:  return 6'h3F;
      4'd1:  return {h[5], v[1], h[6], v[1], h[7], v[1]};
      4'd2:  return {v[5], h[1], v[6], h[1], v[7], h[1]};
      4'd3:  return {xp[5], v[2], xp[6], v[2], xp[7], v[2]};
      4'd4:  return {xm[5], v[2], xm[6], v[2], xm[7], v[2]};
      4'd5:  return {yp[5], v[2], yp[6], v[2], yp[7], v[2]};
      4'd6:  return {ym[5], v[2], ym[6], v[2], ym[7], v[2]};
      4'd7:  return {yp[5], xp[2], yp[6], xp[2], yp[7], xp[2]};
      4'd8:  return {yp[5], xm[2], yp[6], xm[2], yp[7], xm[2]};
      4'd9:  return {ym[5], xp[2], ym[6], xp[2], ym[7], xp[2]};
      4'd10: return {ym[5], xm[2], ym[6], xm[2], ym[7], xm[2]};
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [9:0] exp_addr(input logic [9:0] h, input logic [9:0] v);
    logic [9:0] ox, oy;
    for (int i = 0; i < N; i++) begin
      ox = h - 10'(sx[i]); oy = v - 10'(sy[i]);
      if (ox < S && oy < S) return {oy[4:0], ox[4:0]};
    end
    return 10'd0;
  endfunction

  function automatic logic [5:0] exp_rgb(input logic [9:0] h, input logic [9:0] v, input logic vis);
    logic [9:0] ox, oy;
    logic [5:0] t;
    if (!vis) return 6'h00;
    for (int i = 0; i < N; i++) begin
      ox = h - 10'(sx[i]); oy = v - 10'(sy[i]);
      if (ox < S && oy < S) begin
        t = rom_f({oy[4:0], ox[4:0]});
`ifdef SPRITE_TRANSPARENCY_EN
        if (t == 6'h00) return bg_f(h, v);
`endif
        return t;
      end
    end
    return bg_f(h, v);
  endfunction

  // ---- stimulus helpers ----
  task automatic pixd(input string tag, input logic [9:0] h, input logic [9:0] v,
                      input logic vis, input logic [9:0] ea, input logic [5:0] er);
    bit tk;
    @(negedge clk);
    hpos = h; vpos = v; visible = vis;
    tk = (v == 0) && (last_v != 0);
    last_v = v;
    #1 check({tag, ".addr"}, rom_addr, ea);
    if (tk) m_tick();
    @(negedge clk);
    @(negedge clk);
    check({tag, ".rgb"}, {R, G, B}, er);
  endtask

  task automatic pix(input string tag, input logic [9:0] h, input logic [9:0] v, input logic vis);
    pixd(tag, h, v, vis, exp_addr(h, v), exp_rgb(h, v, vis));
  endtask

  task automatic ftick(input logic [9:0] vprev);
    @(negedge clk);
    hpos = 0; vpos = vprev; visible = 0;
    @(negedge clk);
    vpos = 0; last_v = 0;
    m_tick();
    @(negedge clk);
  endtask

  task automatic chk_s0(input string tag, input int ex, input int ey, input int esc);
    check({tag, ".x"}, 32'(dut.g_spr[0].u_mover.x), ex);
    check({tag, ".y"}, 32'(dut.g_spr[0].u_mover.y), ey);
    check({tag, ".scroll"}, 32'(dut.scroll), esc);
  endtask

  function automatic bit overlap01();
    int ddx, ddy;
    ddx = sx[0] - sx[1]; ddy = sy[0] - sy[1];
    return (ddx < S && ddx > -S && ddy < S && ddy > -S);
  endfunction

  int         modes[11] = '{1, 2, 4, 5, 6, 7, 8, 9, 10, 11, 15};
  logic [9:0] ph[4] = '{10'd37, 10'd250, 10'd5, 10'd600};
  logic [9:0] pv[4] = '{10'd203, 10'd333, 10'd470, 10'd17};
  int         n;
  logic [9:0] oh, ov, ox, oy;
  logic [5:0] ekey;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; hpos = 0; vpos = 0; visible = 0; vga_control = 0;
    repeat (3) @(negedge clk);
    check("rst.rgb", {R, G, B}, 6'h00);
    rst = 0;
    m_reset();
    last_v = 0;
    chk_s0("rst.s0", 100, 80, 0);
    check("rst.s0.dx", 32'(dut.g_spr[0].u_mover.dx), 1);
    check("rst.s1.dy", 32'(dut.g_spr[1].u_mover.dy), 1);

    // Directed pixels at reset positions, mode 0.
    pixd("solid",    0,   0,   1, 10'h000, 6'h3F);
    pixd("blank",    0,   0,   0, 10'h000, 6'h00);
    pixd("s0.org",   100, 80,  1, 10'h000, 6'h15);
    pixd("s0.far",   131, 111, 1, 10'h3FF, 6'h2A);
    pixd("s0.left",  99,  80,  1, 10'h000, 6'h3F);
    pixd("s0.below", 131, 112, 1, 10'h000, 6'h3F);
    pixd("s1.org",   132, 96,  1, 10'h000, 6'h15);
    pixd("s3.far",   227, 159, 1, 10'h3FF, 6'h2A);

    // Mode change only lands at the frame tick.
    vga_control = 8'h03;
    pixd("mid.solid", 20, 300, 1, 10'h000, 6'h3F);
    ftick(10'd524);
    pixd("m3.a",  30,  4,  1, 10'h000, 6'h15);
    pixd("m3.b",  31,  4,  1, 10'h000, 6'h35);
    pixd("m3.s0", 101, 79, 1, 10'h000, 6'h15);

    // Freeze: the tick that latches it still moves, then three held ticks.
    vga_control = 8'h13;
    ftick(10'd524);
    chk_s0("frz0", 102, 78, 2);
    for (int k = 0; k < 3; k++) begin
      ftick(10'd524);
      chk_s0("frz", 102, 78, 2);
    end
    pixd("frz.px", 30, 4, 1, 10'h000, 6'h35);
    vga_control = 8'h03;
    ftick(10'd524);
    chk_s0("unfrz0", 102, 78, 2);
    ftick(10'd524);
    chk_s0("unfrz1", 103, 77, 3);

    // Background mode sweep against the model.
    for (int k = 0; k < 11; k++) begin
      vga_control = 8'(modes[k]);
      ftick(10'd524);
      for (int j = 0; j < 4; j++) pix($sformatf("mode%0d.p%0d", modes[k], j), ph[j], pv[j], 1'b1);
      pix($sformatf("mode%0d.spr", modes[k]), 10'(sx[0] + 7), 10'(sy[0] + 9), 1'b1);
    end

    // Keyed texel (addr 0x015 -> ROM 0) over mode 1 stripes.
    vga_control = 8'h01;
    ftick(10'd524);
`ifdef SPRITE_TRANSPARENCY_EN
    ekey = bg_f(10'(sx[0] + 21), 10'(sy[0]));
`else
    ekey = 6'h00;
`endif
    pixd("tkey", 10'(sx[0] + 21), 10'(sy[0]), 1, 10'h015, ekey);

    // Right and left edge bounces of sprite 0.
    vga_control = 8'h00;
    n = 0;
    while (!(sx[0] == 607 && sdx[0]) && n < 2000) begin ftick(10'd1); n++; end
    check("edgeR.bound", n < 2000, 1);
    check("edgeR.607", 32'(dut.g_spr[0].u_mover.x), 607);
    ftick(10'd1);
    check("edgeR.608", 32'(dut.g_spr[0].u_mover.x), 608);
    check("edgeR.dx", 32'(dut.g_spr[0].u_mover.dx), 0);
    ftick(10'd1);
    check("edgeR.back", 32'(dut.g_spr[0].u_mover.x), 607);
    n = 0;
    while (!(sx[0] == 1 && !sdx[0]) && n < 2000) begin ftick(10'd1); n++; end
    check("edgeL.bound", n < 2000, 1);
    check("edgeL.1", 32'(dut.g_spr[0].u_mover.x), 1);
    ftick(10'd1);
    check("edgeL.0", 32'(dut.g_spr[0].u_mover.x), 0);
    check("edgeL.dx", 32'(dut.g_spr[0].u_mover.dx), 1);
    check("edgeL.y", 32'(dut.g_spr[0].u_mover.y), sy[0]);

    // Run until sprites 0 and 1 overlap; sprite 0 must own the shared pixel.
    n = 0;
    while (!overlap01() && n < 20000) begin ftick(10'd1); n++; end
    check("ovl.bound", n < 20000, 1);
    oh = 10'((sx[0] > sx[1]) ? sx[0] : sx[1]);
    ov = 10'((sy[0] > sy[1]) ? sy[0] : sy[1]);
    ox = oh - 10'(sx[0]);
    oy = ov - 10'(sy[0]);
    pixd("ovl", oh, ov, 1, {oy[4:0], ox[4:0]}, exp_rgb(oh, ov, 1'b1));

    // Reset in the middle of a frame.
    @(negedge clk);
    rst = 1; vpos = 10'd300; hpos = 10'd50; visible = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst2.rgb", {R, G, B}, 6'h00);
    rst = 0;
    m_reset();
    last_v = 10'd300;
    chk_s0("rst2.s0", 100, 80, 0);
    check("rst2.s2.y", 32'(dut.g_spr[2].u_mover.y), 112);
    pixd("rst2.far", 131, 111, 1, 10'h3FF, 6'h2A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
